// File: rtl/adam_fabric_pause_gate.sv
// AXI-Lite per-master gate: bounds outstanding transactions and implements the pause/drain/ack handshake.
// Optional drain timeout is built when ADAM_FABRIC_PAUSE_GATE_TIMEOUT_EN is defined.
module adam_fabric_pause_gate #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    pause_req,
    output logic                    pause_ack,
    output logic                    pause_timeout,

    input  logic [ADDR_WIDTH-1:0]   slv_aw_addr,
    input  logic [2:0]              slv_aw_prot,
    input  logic                    slv_aw_valid,
    output logic                    slv_aw_ready,
    input  logic [DATA_WIDTH-1:0]   slv_w_data,
    input  logic [DATA_WIDTH/8-1:0] slv_w_strb,
    input  logic                    slv_w_valid,
    output logic                    slv_w_ready,
    output logic [1:0]              slv_b_resp,
    output logic                    slv_b_valid,
    input  logic                    slv_b_ready,
    input  logic [ADDR_WIDTH-1:0]   slv_ar_addr,
    input  logic [2:0]              slv_ar_prot,
    input  logic                    slv_ar_valid,
    output logic                    slv_ar_ready,
    output logic [DATA_WIDTH-1:0]   slv_r_data,
    output logic [1:0]              slv_r_resp,
    output logic                    slv_r_valid,
    input  logic                    slv_r_ready,

    output logic [ADDR_WIDTH-1:0]   mst_aw_addr,
    output logic [2:0]              mst_aw_prot,
    output logic                    mst_aw_valid,
    input  logic                    mst_aw_ready,
    output logic [DATA_WIDTH-1:0]   mst_w_data,
    output logic [DATA_WIDTH/8-1:0] mst_w_strb,
    output logic                    mst_w_valid,
    input  logic                    mst_w_ready,
    input  logic [1:0]              mst_b_resp,
    input  logic                    mst_b_valid,
    output logic                    mst_b_ready,
    output logic [ADDR_WIDTH-1:0]   mst_ar_addr,
    output logic [2:0]              mst_ar_prot,
    output logic                    mst_ar_valid,
    input  logic                    mst_ar_ready,
    input  logic [DATA_WIDTH-1:0]   mst_r_data,
    input  logic [1:0]              mst_r_resp,
    input  logic                    mst_r_valid,
    output logic                    mst_r_ready
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

    state_t        state;
    logic [CW-1:0] aw_cnt, w_cnt, rd_cnt;
    logic          allow_aw, allow_w, allow_ar;
    logic          aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic          drained, timeout_hit;

    assign mst_aw_addr  = slv_aw_addr;
    assign mst_aw_prot  = slv_aw_prot;
    assign mst_aw_valid = slv_aw_valid & allow_aw;
    assign slv_aw_ready = mst_aw_ready & allow_aw;
    assign mst_w_data   = slv_w_data;
    assign mst_w_strb   = slv_w_strb;
    assign mst_w_valid  = slv_w_valid & allow_w;
    assign slv_w_ready  = mst_w_ready & allow_w;
    assign mst_ar_addr  = slv_ar_addr;
    assign mst_ar_prot  = slv_ar_prot;
    assign mst_ar_valid = slv_ar_valid & allow_ar;
    assign slv_ar_ready = mst_ar_ready & allow_ar;

    assign slv_b_resp   = mst_b_resp;
    assign slv_b_valid  = mst_b_valid;
    assign mst_b_ready  = slv_b_ready;
    assign slv_r_data   = mst_r_data;
    assign slv_r_resp   = mst_r_resp;
    assign slv_r_valid  = mst_r_valid;
    assign mst_r_ready  = slv_r_ready;

    assign aw_hs = mst_aw_valid & mst_aw_ready;
    assign w_hs  = mst_w_valid & mst_w_ready;
    assign ar_hs = mst_ar_valid & mst_ar_ready;
    assign b_hs  = mst_b_valid & slv_b_ready;
    assign r_hs  = mst_r_valid & slv_r_ready;

    assign drained = (aw_cnt == '0) && (w_cnt == '0) && (rd_cnt == '0);

    // While draining, only the missing half of an already started write may pass.
    always_comb begin
        allow_aw = 1'b0;
        allow_w  = 1'b0;
        allow_ar = 1'b0;
        case (state)
            RUN: begin
                allow_aw = aw_cnt < MAX_CNT;
                allow_w  = w_cnt < MAX_CNT;
                allow_ar = rd_cnt < MAX_CNT;
            end
            DRAIN: begin
                allow_aw = aw_cnt < w_cnt;
                allow_w  = w_cnt < aw_cnt;
            end
            default: ;
        endcase
    end

    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt,
                                               input logic inc, input logic dec);
        if (inc && !dec)
            return cnt + CW'(1);
        if (dec && !inc && cnt != '0)
            return cnt - CW'(1);
        return cnt;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_cnt <= '0;
            w_cnt  <= '0;
            rd_cnt <= '0;
        end else if (timeout_hit) begin
            aw_cnt <= '0;
            w_cnt  <= '0;
            rd_cnt <= '0;
        end else begin
            aw_cnt <= next_cnt(aw_cnt, aw_hs, b_hs);
            w_cnt  <= next_cnt(w_cnt, w_hs, b_hs);
            rd_cnt <= next_cnt(rd_cnt, ar_hs, r_hs);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= RUN;
            pause_ack <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (pause_req)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!pause_req) begin
                        state <= RUN;
                    end else if (drained || timeout_hit) begin
                        state     <= PAUSED;
                        pause_ack <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (!pause_req) begin
                        state     <= RUN;
                        pause_ack <= 1'b0;
                    end
                end
                default: begin
                    state     <= RUN;
                    pause_ack <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADAM_FABRIC_PAUSE_GATE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt;

    assign timeout_hit = (state == DRAIN) && pause_req && (tmo_cnt == TMO_MAX);

    // The flag stays up through PAUSED and drops once the request is released.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt       <= '0;
            pause_timeout <= 1'b0;
        end else begin
            if (state != DRAIN)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (timeout_hit)
                pause_timeout <= 1'b1;
            else if (!pause_req)
                pause_timeout <= 1'b0;
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign pause_timeout = 1'b0;
`endif

    param_sane: assert property (@(posedge clk_i)
        (MAX_OUTSTANDING >= 1) && (TIMEOUT_CYCLES >= 1));

    // After a forced pause, late responses for abandoned transactions are expected.
    b_without_write: assert property (@(posedge clk_i) disable iff (!rst_ni || pause_timeout)
        b_hs |-> (aw_cnt != '0) && (w_cnt != '0));
    r_without_read: assert property (@(posedge clk_i) disable iff (!rst_ni || pause_timeout)
        r_hs |-> (rd_cnt != '0));

endmodule

// File: tb/tb_adam_fabric_pause_gate.sv
// Directed scoreboard bench for adam_fabric_pause_gate (MAX_OUTSTANDING=4, TIMEOUT_CYCLES=16).
// Timeout expectations follow ADAM_FABRIC_PAUSE_GATE_TIMEOUT_EN.
module tb_adam_fabric_pause_gate;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        pause_req;
    logic        pause_ack, pause_timeout;
    logic [31:0] slv_aw_addr;
    logic [2:0]  slv_aw_prot;
    logic        slv_aw_valid, slv_aw_ready;
    logic [31:0] slv_w_data;
    logic [3:0]  slv_w_strb;
    logic        slv_w_valid, slv_w_ready;
    logic [1:0]  slv_b_resp;
    logic        slv_b_valid, slv_b_ready;
    logic [31:0] slv_ar_addr;
    logic [2:0]  slv_ar_prot;
    logic        slv_ar_valid, slv_ar_ready;
    logic [31:0] slv_r_data;
    logic [1:0]  slv_r_resp;
    logic        slv_r_valid, slv_r_ready;
    logic [31:0] mst_aw_addr;
    logic [2:0]  mst_aw_prot;
    logic        mst_aw_valid, mst_aw_ready;
    logic [31:0] mst_w_data;
    logic [3:0]  mst_w_strb;
    logic        mst_w_valid, mst_w_ready;
    logic [1:0]  mst_b_resp;
    logic        mst_b_valid, mst_b_ready;
    logic [31:0] mst_ar_addr;
    logic [2:0]  mst_ar_prot;
    logic        mst_ar_valid, mst_ar_ready;
    logic [31:0] mst_r_data;
    logic [1:0]  mst_r_resp;
    logic        mst_r_valid, mst_r_ready;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [9:0]  ctrl;
        logic [31:0] aw_addr;
        logic [31:0] r_data;
    } exp_t;

    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    adam_fabric_pause_gate #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pause_req(pause_req), .pause_ack(pause_ack), .pause_timeout(pause_timeout),
        .slv_aw_addr(slv_aw_addr), .slv_aw_prot(slv_aw_prot),
        .slv_aw_valid(slv_aw_valid), .slv_aw_ready(slv_aw_ready),
        .slv_w_data(slv_w_data), .slv_w_strb(slv_w_strb),
        .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready),
        .slv_b_resp(slv_b_resp), .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready),
        .slv_ar_addr(slv_ar_addr), .slv_ar_prot(slv_ar_prot),
        .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready),
        .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp),
        .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready),
        .mst_aw_addr(mst_aw_addr), .mst_aw_prot(mst_aw_prot),
        .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready),
        .mst_w_data(mst_w_data), .mst_w_strb(mst_w_strb),
        .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready),
        .mst_b_resp(mst_b_resp), .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready),
        .mst_ar_addr(mst_ar_addr), .mst_ar_prot(mst_ar_prot),
        .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
        .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp),
        .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready)
    );

    // ctrl = {ack, timeout, aw_rdy, w_rdy, ar_rdy, mst_aw_v, mst_w_v, mst_ar_v, slv_b_v, slv_r_v}
    task automatic applyStimulus(input string tag, input logic [9:0] ctrl);
        exp_t e;
        e.tag     = tag;
        e.ctrl    = ctrl;
        e.aw_addr = slv_aw_addr;
        e.r_data  = mst_r_data;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [9:0] got;
        @(negedge clk_i);
        vectors++;
        assert (sb.size() > 0) else begin
            miscompares++;
            $error("[TB] FAIL scoreboard_empty got 0 entries want 1");
        end
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {pause_ack, pause_timeout, slv_aw_ready, slv_w_ready, slv_ar_ready,
                   mst_aw_valid, mst_w_valid, mst_ar_valid, slv_b_valid, slv_r_valid};
            vectors++;
            assert (got === e.ctrl) else begin
                miscompares++;
                $error("[TB] FAIL %s ctrl got %b want %b", e.tag, got, e.ctrl);
            end
            vectors++;
            assert (mst_aw_addr === e.aw_addr) else begin
                miscompares++;
                $error("[TB] FAIL %s aw_addr got %h want %h", e.tag, mst_aw_addr, e.aw_addr);
            end
            vectors++;
            assert (slv_r_data === e.r_data) else begin
                miscompares++;
                $error("[TB] FAIL %s r_data got %h want %h", e.tag, slv_r_data, e.r_data);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic cycle(input string tag, input logic [9:0] ctrl);
        applyStimulus(tag, ctrl);
        checkOutput();
    endtask

    initial begin
        logic [9:0] exp_ctrl;
        rst_ni       = 1'b0;
        pause_req    = 1'b0;
        slv_aw_addr  = 32'h1000_0040;
        slv_aw_prot  = 3'd0;
        slv_aw_valid = 1'b0;
        slv_w_data   = 32'hA5A5_0001;
        slv_w_strb   = 4'hF;
        slv_w_valid  = 1'b0;
        slv_b_ready  = 1'b1;
        slv_ar_addr  = 32'h2000_0000;
        slv_ar_prot  = 3'd0;
        slv_ar_valid = 1'b0;
        slv_r_ready  = 1'b1;
        mst_aw_ready = 1'b1;
        mst_w_ready  = 1'b1;
        mst_b_resp   = 2'b00;
        mst_b_valid  = 1'b0;
        mst_ar_ready = 1'b1;
        mst_r_data   = 32'hCAFE_0001;
        mst_r_resp   = 2'b00;
        mst_r_valid  = 1'b0;

        @(posedge clk_i);
        #1;
        cycle("in_reset", 10'b00_111_000_00);
        rst_ni = 1'b1;
        cycle("idle", 10'b00_111_000_00);

        // Zero-cycle pause and release
        pause_req = 1'b1;
        cycle("req_seen_run", 10'b00_111_000_00);
        cycle("drain_empty", 10'b00_000_000_00);
        cycle("paused", 10'b10_000_000_00);
        cycle("paused_hold", 10'b10_000_000_00);
        pause_req = 1'b0;
        cycle("release_still_paused", 10'b10_000_000_00);
        cycle("back_run", 10'b00_111_000_00);

        // Read outstanding limit
        slv_ar_valid = 1'b1;
        for (int i = 0; i < 4; i++) cycle("ar_accept", 10'b00_111_001_00);
        cycle("ar_fifth_blocked", 10'b00_110_000_00);
        mst_r_valid = 1'b1;
        mst_r_data  = 32'hCAFE_0002;
        cycle("ar_blocked_r_hs", 10'b00_110_000_01);
        mst_r_valid = 1'b0;
        cycle("ar_fifth_accept", 10'b00_111_001_00);
        slv_ar_valid = 1'b0;
        mst_r_valid  = 1'b1;
        cycle("r_drain_full", 10'b00_110_000_01);
        for (int i = 0; i < 3; i++) cycle("r_drain", 10'b00_111_000_01);
        mst_r_valid = 1'b0;

        // AW first, W completed during drain
        slv_aw_addr  = 32'h1000_0080;
        slv_aw_valid = 1'b1;
        cycle("aw_only", 10'b00_111_100_00);
        slv_aw_valid = 1'b0;
        pause_req    = 1'b1;
        cycle("req_aw_pending", 10'b00_111_000_00);
        slv_ar_valid = 1'b1;
        cycle("drain_w_allowed", 10'b00_010_000_00);
        slv_w_valid = 1'b1;
        cycle("drain_w_accept", 10'b00_010_010_00);
        slv_w_valid = 1'b0;
        cycle("drain_wait_b", 10'b00_000_000_00);
        cycle("drain_wait_b", 10'b00_000_000_00);
        mst_b_valid = 1'b1;
        cycle("drain_b_hs", 10'b00_000_000_10);
        mst_b_valid = 1'b0;
        cycle("drain_after_b", 10'b00_000_000_00);
        cycle("paused_after_b", 10'b10_000_000_00);
        slv_ar_valid = 1'b0;
        pause_req    = 1'b0;
        cycle("release_w1", 10'b10_000_000_00);
        cycle("run_w1", 10'b00_111_000_00);

        // W first, matching AW during drain, second AW blocked
        slv_w_valid = 1'b1;
        cycle("w_only", 10'b00_111_010_00);
        slv_w_valid = 1'b0;
        pause_req   = 1'b1;
        cycle("req_w_pending", 10'b00_111_000_00);
        slv_aw_addr  = 32'h1000_00C0;
        slv_aw_valid = 1'b1;
        cycle("drain_aw_accept", 10'b00_100_100_00);
        cycle("drain_aw2_blocked", 10'b00_000_000_00);
        slv_aw_valid = 1'b0;
        mst_b_valid  = 1'b1;
        cycle("drain_b2_hs", 10'b00_000_000_10);
        mst_b_valid = 1'b0;
        cycle("drain_after_b2", 10'b00_000_000_00);
        cycle("paused_after_b2", 10'b10_000_000_00);
        pause_req = 1'b0;
        cycle("release_w2", 10'b10_000_000_00);
        cycle("run_w2", 10'b00_111_000_00);

        // Short pause pulse with reads in flight
        slv_ar_valid = 1'b1;
        cycle("ar_pulse_a", 10'b00_111_001_00);
        cycle("ar_pulse_b", 10'b00_111_001_00);
        slv_ar_valid = 1'b0;
        pause_req    = 1'b1;
        cycle("pulse_run", 10'b00_111_000_00);
        cycle("pulse_drain", 10'b00_000_000_00);
        pause_req = 1'b0;
        cycle("pulse_drop", 10'b00_000_000_00);
        slv_ar_valid = 1'b1;
        cycle("ar_after_pulse", 10'b00_111_001_00);
        slv_ar_valid = 1'b0;
        mst_r_valid  = 1'b1;
        mst_r_data   = 32'hCAFE_0003;
        for (int i = 0; i < 3; i++) cycle("r_after_pulse", 10'b00_111_000_01);
        mst_r_valid = 1'b0;

        // Unanswered read, then pause
        slv_ar_valid = 1'b1;
        cycle("ar_stuck", 10'b00_111_001_00);
        slv_ar_valid = 1'b0;
        pause_req    = 1'b1;
        cycle("req_stuck", 10'b00_111_000_00);
        for (int k = 0; k < 100; k++) begin
`ifdef ADAM_FABRIC_PAUSE_GATE_TIMEOUT_EN
            exp_ctrl = (k >= 17) ? 10'b11_000_000_00 : 10'b00_000_000_00;
`else
            exp_ctrl = 10'b00_000_000_00;
`endif
            cycle("timeout_drain", exp_ctrl);
        end
        pause_req = 1'b0;
`ifdef ADAM_FABRIC_PAUSE_GATE_TIMEOUT_EN
        cycle("timeout_release", 10'b11_000_000_00);
        cycle("timeout_run", 10'b00_111_000_00);
`else
        cycle("stuck_release", 10'b00_000_000_00);
        mst_r_valid = 1'b1;
        cycle("stuck_r_hs", 10'b00_111_000_01);
        mst_r_valid = 1'b0;
        cycle("stuck_done", 10'b00_111_000_00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got running want finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
